// File: rtl/counter_ctrl.sv
// Command-driven initiator for the loadable up/down counter: loads a start value, counts N steps, tracks OUT.
// Optional COUNTER_CHECK_EN adds an OUT input and a sticky MISMATCH flag comparing OUT against EXP_OUT.
module counter_ctrl #(
   parameter int N      = 8,
   parameter int STEP_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [N-1:0]      CMD_START,
   input  logic [STEP_W-1:0] CMD_STEPS,
   input  logic              CMD_DIR,
   output logic [N-1:0]      DATA_IN,
   output logic              LOAD,
   output logic              E,
   output logic              D,
   output logic [N-1:0]      EXP_OUT,
   output logic              BUSY,
   output logic              DONE
`ifdef COUNTER_CHECK_EN
   ,
   input  logic [N-1:0]      OUT,
   output logic              MISMATCH
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_FIN} state_t;

   localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] ONE_STEP = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] ZERO_STEP = '0;

   state_t            state;
   state_t            state_nxt;
   logic [STEP_W-1:0] remaining;
   logic              dir;
   logic              accept;

   assign accept = CMD_VALID & CMD_READY;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = (remaining == ZERO_STEP) ? S_FIN : S_COUNT;
         S_COUNT: if (remaining == ONE_STEP) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CMD_READY <= 1'b0;
         LOAD      <= 1'b0;
         E         <= 1'b0;
         D         <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         DATA_IN   <= '0;
         EXP_OUT   <= '0;
         remaining <= '0;
         dir       <= 1'b0;
      end else begin
         CMD_READY <= (state_nxt == S_IDLE);
         LOAD      <= (state_nxt == S_LOAD);
         E         <= (state_nxt == S_COUNT);
         BUSY      <= (state_nxt != S_IDLE);
         DONE      <= (state_nxt == S_FIN);
         if (accept) begin
            DATA_IN   <= CMD_START;
            remaining <= CMD_STEPS;
            dir       <= CMD_DIR;
         end else if (state == S_COUNT) begin
            remaining <= remaining - ONE_STEP;
         end
         if (state_nxt == S_COUNT) D <= dir;
         // Mirror the counter: it sees the same registered LOAD/E/D on the same edge.
         if (LOAD)      EXP_OUT <= DATA_IN;
         else if (E)    EXP_OUT <= D ? (EXP_OUT - ONE_N) : (EXP_OUT + ONE_N);
      end
   end

`ifdef COUNTER_CHECK_EN
   logic armed;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         armed    <= 1'b0;
         MISMATCH <= 1'b0;
      end else begin
         if (LOAD) armed <= 1'b1;
         if (accept)                          MISMATCH <= 1'b0;
         else if (armed && (OUT != EXP_OUT))  MISMATCH <= 1'b1;
      end
   end
`endif

endmodule
